// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_prio_select.sv
// Two-way grant picker (fetch vs data). Defining MEM_ARB_ROUND_ROBIN_EN
// alternates winners under contention; otherwise data always wins.
module arb_prio_select (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt,
  output logic ptr_o
);

  logic d_wins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_q=0 favours data, ptr_q=1 favours fetch; only contended grants move it.
  logic ptr_q, ptr_d;

  always_comb begin
    d_wins = ~ptr_q;
    ptr_d  = ptr_q;
    if (en && if_req && d_req) ptr_d = d_wins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign d_wins = 1'b1;
  assign ptr_o  = 1'b0;
`endif

  always_comb begin
    d_gnt  = en & d_req & (~if_req | d_wins);
    if_gnt = en & if_req & ~d_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and load/store.
// Contention policy selected by MEM_ARB_ROUND_ROBIN_EN (see arb_prio_select).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner_dbg_o
);

  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_q;
  logic          ptr_unused;

  arb_prio_select u_sel (
    .clk    (clk),
    .rst    (reset),
    .en     (~reset),
    .if_req (if_req),
    .d_req  (d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt),
    .ptr_o  (ptr_unused)
  );

  always_comb begin
    mem_addr = addr_q;
    if (d_gnt)       mem_addr = d_addr;
    else if (if_gnt) mem_addr = if_addr;

    // A fetch flushed in its own grant cycle is never tracked.
    owner_d = OWN_NONE;
    if (d_gnt && !d_we)         owner_d = OWN_D;
    else if (if_gnt && !if_flush) owner_d = OWN_IF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= mem_addr;
    end
  end

  assign mem_we      = d_gnt & d_we;
  assign mem_wdata   = d_wdata;
  assign if_rdata    = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign if_rvalid   = (owner_q == OWN_IF) & ~if_flush;
  assign d_rvalid    = (owner_q == OWN_D);
  assign busy        = (owner_q != OWN_NONE) | if_req | d_req;
  assign owner_dbg_o = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  owner_dbg;
  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner_dbg_o(owner_dbg)
  );

  // Memory: write committed at the edge ending the grant cycle, read data one cycle later.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #4;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0044; if_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0066; d_wdata = 16'hDEAD;
    tick; tick; settle;
    chk("reset_if_gnt", {15'd0, if_gnt}, 16'd0);
    chk("reset_d_gnt", {15'd0, d_gnt}, 16'd0);
    chk("reset_mem_we", {15'd0, mem_we}, 16'd0);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_if_rvalid", {15'd0, if_rvalid}, 16'd0);
    chk("reset_d_rvalid", {15'd0, d_rvalid}, 16'd0);
    tick;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b0;
    settle;
    chk("post_reset_owner", {14'd0, owner_dbg}, 16'd0);
    chk("post_reset_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_fetch;
    tick;
    if_req = 1'b1; if_addr = 16'h0010;
    settle;
    chk("fetch_if_gnt", {15'd0, if_gnt}, 16'd1);
    chk("fetch_d_gnt", {15'd0, d_gnt}, 16'd0);
    chk("fetch_mem_addr", mem_addr, 16'h0010);
    chk("fetch_mem_we", {15'd0, mem_we}, 16'd0);
    chk("fetch_busy", {15'd0, busy}, 16'd1);
    tick;
    if_req = 1'b0;
    settle;
    chk("fetch_if_rvalid", {15'd0, if_rvalid}, 16'd1);
    chk("fetch_if_rdata", if_rdata, 16'hA5A5);
    chk("fetch_no_d_rvalid", {15'd0, d_rvalid}, 16'd0);
    chk("fetch_addr_hold", mem_addr, 16'h0010);
    tick;
    settle;
    chk("fetch_rvalid_clear", {15'd0, if_rvalid}, 16'd0);
    chk("fetch_idle_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_store_load;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    settle;
    chk("store_d_gnt", {15'd0, d_gnt}, 16'd1);
    chk("store_mem_we", {15'd0, mem_we}, 16'd1);
    chk("store_mem_addr", mem_addr, 16'h0200);
    chk("store_mem_wdata", mem_wdata, 16'h1234);
    tick;
    d_we = 1'b0;
    settle;
    chk("store_no_rvalid", {15'd0, d_rvalid}, 16'd0);
    chk("load_d_gnt", {15'd0, d_gnt}, 16'd1);
    chk("load_mem_we", {15'd0, mem_we}, 16'd0);
    tick;
    d_req = 1'b0;
    settle;
    chk("load_d_rvalid", {15'd0, d_rvalid}, 16'd1);
    chk("load_d_rdata", d_rdata, 16'h1234);
    chk("load_no_if_rvalid", {15'd0, if_rvalid}, 16'd0);
    tick;
    settle;
    chk("load_rvalid_clear", {15'd0, d_rvalid}, 16'd0);
  endtask

  task automatic test_contention;
    logic exp_d [0:3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
    tick;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk($sformatf("cont_d_gnt_%0d", i), {15'd0, d_gnt}, {15'd0, exp_d[i]});
      chk($sformatf("cont_if_gnt_%0d", i), {15'd0, if_gnt}, {15'd0, ~exp_d[i]});
      chk($sformatf("cont_mem_addr_%0d", i), mem_addr, exp_d[i] ? 16'h0100 : 16'h0010);
      if (i > 0) begin
        chk($sformatf("cont_d_rvalid_%0d", i), {15'd0, d_rvalid}, {15'd0, exp_d[i-1]});
        chk($sformatf("cont_if_rvalid_%0d", i), {15'd0, if_rvalid}, {15'd0, ~exp_d[i-1]});
        chk($sformatf("cont_rdata_%0d", i), d_rdata, exp_d[i-1] ? 16'hBEEF : 16'hA5A5);
      end
      tick;
    end
    if_req = 1'b0; d_req = 1'b0;
    settle;
    chk("cont_d_rvalid_last", {15'd0, d_rvalid}, {15'd0, exp_d[3]});
    chk("cont_if_rvalid_last", {15'd0, if_rvalid}, {15'd0, ~exp_d[3]});
  endtask

  task automatic test_flush;
    tick;
    if_req = 1'b1; if_addr = 16'h0020;
    settle;
    chk("flush_if_gnt", {15'd0, if_gnt}, 16'd1);
    tick;
    if_req = 1'b0; if_flush = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    settle;
    chk("flush_if_rvalid_sup", {15'd0, if_rvalid}, 16'd0);
    chk("flush_d_gnt", {15'd0, d_gnt}, 16'd1);
    tick;
    if_flush = 1'b0; d_req = 1'b0;
    settle;
    chk("flush_d_rvalid", {15'd0, d_rvalid}, 16'd1);
    chk("flush_d_rdata", d_rdata, 16'hBEEF);
    chk("flush_if_rvalid_after", {15'd0, if_rvalid}, 16'd0);
    // Flush asserted in the fetch's own grant cycle.
    tick;
    if_req = 1'b1; if_addr = 16'h0030; if_flush = 1'b1;
    settle;
    chk("flush_grant_if_gnt", {15'd0, if_gnt}, 16'd1);
    tick;
    if_req = 1'b0; if_flush = 1'b0;
    settle;
    chk("flush_grant_if_rvalid", {15'd0, if_rvalid}, 16'd0);
    chk("flush_grant_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_reset_mid;
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    settle;
    chk("rmid_d_gnt", {15'd0, d_gnt}, 16'd1);
    tick;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0010; d_we = 1'b1; d_wdata = 16'h7777;
    settle;
    chk("rmid_d_rvalid", {15'd0, d_rvalid}, 16'd0);
    chk("rmid_d_gnt_forced", {15'd0, d_gnt}, 16'd0);
    chk("rmid_if_gnt_forced", {15'd0, if_gnt}, 16'd0);
    chk("rmid_mem_we", {15'd0, mem_we}, 16'd0);
    tick;
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    settle;
    chk("rmid_no_rvalid_after", {15'd0, d_rvalid}, 16'd0);
    chk("rmid_mem_0100_kept", mem[16'h0100], 16'hBEEF);
    test_fetch;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0020] = 16'h5A5A;
    mem[16'h0030] = 16'h1111;
    mem[16'h0100] = 16'hBEEF;
    test_reset;
    test_fetch;
    test_store_load;
    test_contention;
    test_flush;
    test_reset_mid;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
